// File: rtl/aes_pkg.sv
// Shared AES control definitions: key-size encodings, round counts, FSM states.
package aes_pkg;

  localparam logic [1:0] KS_128 = 2'b00;
  localparam logic [1:0] KS_192 = 2'b01;
  localparam logic [1:0] KS_256 = 2'b10;

  localparam int unsigned NR_128 = 10;
  localparam int unsigned NR_192 = 12;
  localparam int unsigned NR_256 = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Round count for a key-size select; both 10 and 11 mean AES-256.
  function automatic logic [3:0] nr_of(input logic [1:0] ks);
    logic [3:0] nr;
    nr = 4'(NR_256);
    if (ks == KS_128) begin
      nr = 4'(NR_128);
    end else if (ks == KS_192) begin
      nr = 4'(NR_192);
    end else if (ks == KS_256) begin
      nr = 4'(NR_256);
    end
    return nr;
  endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// Sequencer for the iterative AES encryption round datapath: accepts a block,
// applies the initial AddRoundKey, steps the round unit Nr times and hands the
// ciphertext out through a valid/ready handshake.
import aes_pkg::*;

module aes_round_ctrl #(
  parameter int unsigned RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_pt,
  input  logic [1:0]    in_ks,
  output logic [RW-1:0] rk_idx,
  input  logic [127:0]  rk,
  output logic [127:0]  rd_state,
  output logic [127:0]  rd_key,
  output logic          rd_final,
  input  logic [127:0]  rd_out,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_ct,
  output logic          busy
);

  state_t        state;
  logic [127:0]  state_reg;
  logic [RW-1:0] rnd;
  logic [RW-1:0] nr_reg;
  logic [RW-1:0] rnd_inc;

  // Acceptance is decided purely by the FSM state.
  assign in_ready = (state == IDLE);

  // The working state register feeds both the round unit and the result port.
  assign rd_state = state_reg;
  assign out_ct   = state_reg;
  assign rd_key   = rk;

  assign rnd_inc  = rnd + RW'(1);

  // Control FSM; rk_idx and rd_final are precomputed for the upcoming state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      state_reg <= '0;
      rnd       <= '0;
      nr_reg    <= RW'(NR_128);
      rk_idx    <= '0;
      rd_final  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state_reg <= in_pt;
            nr_reg    <= RW'(nr_of(in_ks));
            rnd       <= '0;
            rk_idx    <= '0;
            busy      <= 1'b1;
            state     <= INIT;
          end
        end
        INIT: begin
          state_reg <= state_reg ^ rk;
          rnd       <= RW'(1);
          rk_idx    <= RW'(1);
          rd_final  <= (nr_reg == RW'(1));
          state     <= ROUND;
        end
        ROUND: begin
          state_reg <= rd_out;
          if (rnd == nr_reg) begin
            rk_idx    <= '0;
            rd_final  <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            rnd      <= rnd_inc;
            rk_idx   <= rnd_inc;
            rd_final <= (rnd_inc == nr_reg);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: reference key expansion and round unit around the
// controller, FIPS-197 vectors, backpressure, mid-block reset and key-size changes.
module tb_aes_round_ctrl;

  localparam int unsigned RW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [127:0]  in_pt;
  logic [1:0]    in_ks;
  logic [RW-1:0] rk_idx;
  logic [127:0]  rk;
  logic [127:0]  rd_state;
  logic [127:0]  rd_key;
  logic          rd_final;
  logic [127:0]  rd_out;
  logic          out_valid;
  logic          out_ready;
  logic [127:0]  out_ct;
  logic          busy;

  aes_round_ctrl #(.RW(RW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pt     (in_pt),
    .in_ks     (in_ks),
    .rk_idx    (rk_idx),
    .rk        (rk),
    .rd_state  (rd_state),
    .rd_key    (rd_key),
    .rd_final  (rd_final),
    .rd_out    (rd_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ct    (out_ct),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   ks;
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  typedef struct {
    logic [127:0] ct;
    int           lat;
  } exp_t;

  vec_t         vecs [3];
  exp_t         sb [$];
  logic [7:0]   sbox [256];
  logic [127:0] rks [16];
  int           checks = 0;
  int           errors = 0;

  // Key-schedule store: same-cycle lookup by index.
  assign rk = rks[rk_idx];

  // ---------------- reference AES model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic build_sbox();
    logic [7:0] b;
    logic [7:0] inv;
    for (int i = 0; i < 256; i++) begin
      b   = 8'(i);
      inv = 8'h00;
      for (int j = 1; j < 256; j++) begin
        if (gm(b, 8'(j)) == 8'h01) inv = 8'(j);
      end
      sbox[i] = inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic expand_key(input logic [255:0] key, input int nr);
    logic [31:0] w [64];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nk;
    nk = (nr == 10) ? 4 : (nr == 12) ? 6 : 8;
    for (int i = 0; i < 64; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) begin
      rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
  endtask

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic fin);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   c0, c1, c2, c3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) b[r+4*c] = a[r+4*((c+r)%4)];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        c0 = b[4*c]; c1 = b[4*c+1]; c2 = b[4*c+2]; c3 = b[4*c+3];
        b[4*c]   = xt(c0) ^ xt(c1) ^ c1 ^ c2 ^ c3;
        b[4*c+1] = c0 ^ xt(c1) ^ xt(c2) ^ c2 ^ c3;
        b[4*c+2] = c0 ^ c1 ^ xt(c2) ^ xt(c3) ^ c3;
        b[4*c+3] = xt(c0) ^ c0 ^ c1 ^ c2 ^ xt(c3);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
    return o ^ k;
  endfunction

  // Round unit: one full (or final) AES round, same-cycle.
  always_comb rd_out = aes_round(rd_state, rd_key, rd_final);

  // ---------------- checking helpers ----------------
  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int nr_model(input logic [1:0] ks);
    return (ks == 2'b00) ? 10 : (ks == 2'b01) ? 12 : 14;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One block from accept to ciphertext handshake, with optional stall and in_ks toggle.
  task automatic run_block(input int vi, input int stall, input bit tog);
    vec_t         v;
    exp_t         e;
    int           nr;
    bit           got;
    logic [127:0] ct_seen;
    v  = vecs[vi];
    nr = nr_model(v.ks);
    expand_key(v.key, nr);
    check("idle_in_ready", 128'(in_ready), 128'(1));
    in_valid = 1'b1;
    in_pt    = v.pt;
    in_ks    = v.ks;
    e.ct     = v.ct;
    e.lat    = nr + 2;
    sb.push_back(e);
    tick();
    in_valid = 1'b0;
    in_pt    = {$urandom, $urandom, $urandom, $urandom};
    in_ks    = tog ? 2'b10 : 2'($urandom);
    got      = 1'b0;
    for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
      if (out_valid) begin
        got = 1'b1;
        if (sb.size() == 0) begin
          check("sb_underflow", 128'(0), 128'(1));
        end else begin
          e = sb.pop_front();
          check("latency", 128'(cyc), 128'(e.lat));
          check("out_ct", out_ct, e.ct);
        end
        check("done_rd_final", 128'(rd_final), 128'(0));
        check("done_rk_idx", 128'(rk_idx), 128'(0));
      end else begin
        check("busy", 128'(busy), 128'(1));
        check("rd_final", 128'(rd_final), 128'(cyc == nr + 1));
        check("rk_idx", 128'(rk_idx), 128'((cyc == 1) ? 0 : cyc - 1));
        tick();
      end
    end
    if (!got) begin
      check("out_valid_timeout", 128'(0), 128'(1));
      return;
    end
    ct_seen = out_ct;
    for (int s = 0; s < stall; s++) begin
      in_valid = (s % 2 == 0);
      tick();
      check("stall_out_ct", out_ct, ct_seen);
      check("stall_out_valid", 128'(out_valid), 128'(1));
      check("stall_in_ready", 128'(in_ready), 128'(0));
      check("stall_busy", 128'(busy), 128'(1));
    end
    out_ready = 1'b1;
    in_valid  = (stall > 0);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("post_in_ready", 128'(in_ready), 128'(1));
    check("post_busy", 128'(busy), 128'(0));
    check("post_out_valid", 128'(out_valid), 128'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 128'(in_ready), 128'(1));
    check({tag, "_out_valid"}, 128'(out_valid), 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
    check({tag, "_rd_final"}, 128'(rd_final), 128'(0));
    check({tag, "_rk_idx"}, 128'(rk_idx), 128'(0));
    check({tag, "_out_ct"}, out_ct, 128'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int spurious;
    vecs[0] = '{ks: 2'b00, key: {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                pt: 128'h00112233445566778899aabbccddeeff,
                ct: 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{ks: 2'b01, key: {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                pt: 128'h00112233445566778899aabbccddeeff,
                ct: 128'hdda97ca4864cdfe06eaf70a0ec0d7191};
    vecs[2] = '{ks: 2'b11,
                key: 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                pt: 128'h00112233445566778899aabbccddeeff,
                ct: 128'h8ea2b7ca516745bfeafc49904b496089};

    build_sbox();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_pt     = '0;
    in_ks     = 2'b00;
    out_ready = 1'b0;
    tick();
    tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 3; i++) run_block(i, (i == 2) ? 5 : 0, 1'b0);

    // Reset during round 5 of an AES-128 block discards it.
    expand_key(vecs[0].key, 10);
    in_valid = 1'b1;
    in_pt    = vecs[0].pt;
    in_ks    = vecs[0].ks;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    check("mid_rk_idx", 128'(rk_idx), 128'(5));
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midrst");
    rst_n    = 1'b1;
    spurious = 0;
    repeat (20) begin
      tick();
      if (out_valid) spurious++;
    end
    check("midrst_no_output", 128'(spurious), 128'(0));

    run_block(0, 0, 1'b0);
    run_block(0, 2, 1'b1);

    check("sb_empty", 128'(sb.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
